// File: rtl/config_pkg.sv
// Core configuration record shared by front-end and LSU blocks.
package config_pkg;

  typedef struct packed {
    int unsigned INSTR_PER_FETCH;
    int unsigned PLEN;
    int unsigned XLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{INSTR_PER_FETCH: 32'd4, PLEN: 32'd32, XLEN: 32'd32};

endpackage

// File: rtl/lsu_pkg.sv
// LSU-side types: store buffer entry payload and wrap-tagged queue pointer.
package lsu_pkg;

  localparam int unsigned PLEN     = config_pkg::EmptyCfg.PLEN;
  localparam int unsigned XLEN     = config_pkg::EmptyCfg.XLEN;
  localparam int unsigned SB_IDX_W = 4;

  typedef struct packed {
    logic              valid;
    logic              data_ok;
    logic              committed;
    logic [PLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] strb;
  } sb_entry_t;

  typedef struct packed {
    logic                wrap;
    logic [SB_IDX_W-1:0] idx;
  } sb_ptr_t;

endpackage

// File: rtl/sb_alloc_idx.sv
// Prefix popcount over W request lanes: per-lane offset plus group total.
module sb_alloc_idx #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]         req_i,
  output logic [W-1:0][CW-1:0] offs_o,
  output logic [CW-1:0]        total_o
);

  logic [CW-1:0] acc_c;

  always_comb begin
    acc_c  = '0;
    offs_o = '0;
    for (int i = 0; i < int'(W); i++) begin
      offs_o[i] = acc_c;
      acc_c     = acc_c + CW'(req_i[i]);
    end
    total_o = acc_c;
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: allocate from rename, fill from LSU, commit from ROB,
// drain committed entries one per cycle to the D-cache.
module store_buffer
  import lsu_pkg::*;
#(
  parameter config_pkg::cfg_t Cfg          = config_pkg::EmptyCfg,
  parameter int unsigned      SB_DEPTH     = 16,
  parameter int unsigned      SB_IDX_WIDTH = $clog2(SB_DEPTH)
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic [Cfg.INSTR_PER_FETCH-1:0]                  sb_alloc_req_i,
  input  logic                                            sb_alloc_fire_i,
  output logic                                            sb_alloc_ready_o,
  output logic [Cfg.INSTR_PER_FETCH-1:0][SB_IDX_WIDTH-1:0] sb_alloc_id_o,
  input  logic                                            exe_valid_i,
  input  logic [SB_IDX_WIDTH-1:0]                         exe_sb_id_i,
  input  logic [Cfg.PLEN-1:0]                             exe_addr_i,
  input  logic [Cfg.XLEN-1:0]                             exe_data_i,
  input  logic [Cfg.XLEN/8-1:0]                           exe_strb_i,
  input  logic [Cfg.INSTR_PER_FETCH-1:0]                  commit_store_i,
  output logic                                            dc_req_valid_o,
  input  logic                                            dc_req_ready_i,
  output logic [Cfg.PLEN-1:0]                             dc_req_addr_o,
  output logic [Cfg.XLEN-1:0]                             dc_req_data_o,
  output logic [Cfg.XLEN/8-1:0]                           dc_req_strb_o,
  output logic                                            sb_empty_o,
  input  logic                                            flush_i
);

  localparam int unsigned W  = Cfg.INSTR_PER_FETCH;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned IW = SB_IDX_WIDTH;
  localparam int unsigned PW = SB_IDX_WIDTH + 1;

  logic [PW-1:0]        head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  sb_entry_t            ent_q [SB_DEPTH];
  sb_entry_t            ent_d [SB_DEPTH];
  sb_entry_t            head_ent_c;
  logic [W-1:0][CW-1:0] alloc_offs_c, cmt_offs_c;
  logic [CW-1:0]        alloc_total_c, cmt_total_c;
  logic [PW-1:0]        count_c, free_c;
  logic                 alloc_en_c, exe_hit_c, pop_c, commit_err_c;

  sb_alloc_idx #(.W(W), .CW(CW)) u_alloc_idx (
    .req_i   (sb_alloc_req_i),
    .offs_o  (alloc_offs_c),
    .total_o (alloc_total_c)
  );

  sb_alloc_idx #(.W(W), .CW(CW)) u_cmt_idx (
    .req_i   (commit_store_i),
    .offs_o  (cmt_offs_c),
    .total_o (cmt_total_c)
  );

  // Membership in the circular window [lo, hi).
  function automatic logic in_range(input logic [IW-1:0] idx, input logic [PW-1:0] lo,
                                    input logic [PW-1:0] hi);
    logic [IW-1:0] off;
    off = idx - lo[IW-1:0];
    return PW'(off) < (hi - lo);
  endfunction

  assign count_c          = tail_q - head_q;
  assign free_c           = PW'(SB_DEPTH) - count_c;
  assign sb_alloc_ready_o = free_c >= PW'(W);
  assign sb_empty_o       = head_q == tail_q;
  assign alloc_en_c       = sb_alloc_fire_i && sb_alloc_ready_o && !flush_i;
  assign exe_hit_c        = exe_valid_i && !flush_i && ent_q[exe_sb_id_i].valid
                            && !ent_q[exe_sb_id_i].committed;

  always_comb begin
    sb_alloc_id_o = '0;
    for (int l = 0; l < int'(W); l++) begin
      sb_alloc_id_o[l] = tail_q[IW-1:0] + IW'(alloc_offs_c[l]);
    end
  end

  assign head_ent_c     = ent_q[head_q[IW-1:0]];
  assign dc_req_valid_o = head_ent_c.valid && head_ent_c.committed && head_ent_c.data_ok;
  assign dc_req_addr_o  = head_ent_c.addr;
  assign dc_req_data_o  = head_ent_c.data;
  assign dc_req_strb_o  = head_ent_c.strb;
  assign pop_c          = dc_req_valid_o && dc_req_ready_i;

  // Next-state for pointers and entries; flush trims after commit is applied.
  always_comb begin
    for (int i = 0; i < int'(SB_DEPTH); i++) ent_d[i] = ent_q[i];
    head_d = head_q;
    cmt_d  = cmt_q + PW'(cmt_total_c);
    tail_d = tail_q;

    if (pop_c) begin
      ent_d[head_q[IW-1:0]] = '0;
      head_d                = head_q + PW'(1);
    end

    for (int l = 0; l < int'(W); l++) begin
      if (commit_store_i[l]) ent_d[IW'(cmt_q[IW-1:0] + IW'(cmt_offs_c[l]))].committed = 1'b1;
    end

    if (exe_hit_c) begin
      ent_d[exe_sb_id_i].addr    = exe_addr_i;
      ent_d[exe_sb_id_i].data    = exe_data_i;
      ent_d[exe_sb_id_i].strb    = exe_strb_i;
      ent_d[exe_sb_id_i].data_ok = 1'b1;
    end

    if (alloc_en_c) begin
      for (int l = 0; l < int'(W); l++) begin
        if (sb_alloc_req_i[l]) begin
          ent_d[IW'(tail_q[IW-1:0] + IW'(alloc_offs_c[l]))]       = '0;
          ent_d[IW'(tail_q[IW-1:0] + IW'(alloc_offs_c[l]))].valid = 1'b1;
        end
      end
      tail_d = tail_q + PW'(alloc_total_c);
    end

    if (flush_i) begin
      for (int i = 0; i < int'(SB_DEPTH); i++) begin
        if (in_range(IW'(i), cmt_d, tail_q)) ent_d[i] = '0;
      end
      tail_d = cmt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      for (int i = 0; i < int'(SB_DEPTH); i++) ent_q[i] <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      for (int i = 0; i < int'(SB_DEPTH); i++) ent_q[i] <= ent_d[i];
    end
  end

  // A retiring store must already hold its data, or receive it this cycle.
  always_comb begin
    commit_err_c = 1'b0;
    for (int l = 0; l < int'(W); l++) begin
      if (commit_store_i[l]
          && !ent_q[IW'(cmt_q[IW-1:0] + IW'(cmt_offs_c[l]))].data_ok
          && !(exe_hit_c && exe_sb_id_i == IW'(cmt_q[IW-1:0] + IW'(cmt_offs_c[l]))))
        commit_err_c = 1'b1;
    end
  end

  a_commit_needs_data: assert property (@(posedge clk_i) disable iff (!rst_ni) !commit_err_c);

endmodule

// File: tb/tb_store_buffer.sv
// Randomized scoreboard bench for store_buffer against a queue-based reference model.
module tb_store_buffer;

  localparam int W = 4;
  localparam int D = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        sb_alloc_req;
  logic              sb_alloc_fire;
  logic              sb_alloc_ready;
  logic [3:0][3:0]   sb_alloc_id;
  logic              exe_valid;
  logic [3:0]        exe_sb_id;
  logic [31:0]       exe_addr;
  logic [31:0]       exe_data;
  logic [3:0]        exe_strb;
  logic [3:0]        commit_store;
  logic              dc_req_valid;
  logic              dc_req_ready;
  logic [31:0]       dc_req_addr;
  logic [31:0]       dc_req_data;
  logic [3:0]        dc_req_strb;
  logic              sb_empty;
  logic              flush;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .sb_alloc_req_i   (sb_alloc_req),
    .sb_alloc_fire_i  (sb_alloc_fire),
    .sb_alloc_ready_o (sb_alloc_ready),
    .sb_alloc_id_o    (sb_alloc_id),
    .exe_valid_i      (exe_valid),
    .exe_sb_id_i      (exe_sb_id),
    .exe_addr_i       (exe_addr),
    .exe_data_i       (exe_data),
    .exe_strb_i       (exe_strb),
    .commit_store_i   (commit_store),
    .dc_req_valid_o   (dc_req_valid),
    .dc_req_ready_i   (dc_req_ready),
    .dc_req_addr_o    (dc_req_addr),
    .dc_req_data_o    (dc_req_data),
    .dc_req_strb_o    (dc_req_strb),
    .sb_empty_o       (sb_empty),
    .flush_i          (flush)
  );

  typedef struct {
    bit          dok;
    bit          cmt;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ment_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } drain_t;

  ment_t  ent[$];     // live stores, oldest first
  drain_t exp_q[$];   // expected D-cache writes, in order
  int     head_seq = 0;
  int     ncmt = 0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drain monitor: every presented request must match the oldest committed store.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && dc_req_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drain_unexpected actual=%0h required=none", dc_req_addr);
        end else begin
          chk("drain_addr", 64'(dc_req_addr), 64'(exp_q[0].addr));
          chk("drain_data", 64'(dc_req_data), 64'(exp_q[0].data));
          chk("drain_strb", 64'(dc_req_strb), 64'(exp_q[0].strb));
          if (dc_req_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One cycle: drive, check combinational outputs mid-cycle, advance the model.
  task automatic step(input logic [3:0] req, input logic fire, input logic ev,
                      input logic [3:0] eid, input logic [31:0] ea, input logic [31:0] ed,
                      input logic [3:0] es, input logic [3:0] cm, input logic rdy,
                      input logic fl);
    int cnt, pre, k, c;
    bit mrdy, vh;
    sb_alloc_req = req; sb_alloc_fire = fire;
    exe_valid = ev; exe_sb_id = eid; exe_addr = ea; exe_data = ed; exe_strb = es;
    commit_store = cm; dc_req_ready = rdy; flush = fl;
    cnt  = ent.size();
    mrdy = (D - cnt) >= W;
    vh   = (cnt > 0) && ent[0].cmt;
    @(negedge clk);
    chk("alloc_ready", 64'(sb_alloc_ready), 64'(mrdy));
    chk("sb_empty", 64'(sb_empty), 64'(cnt == 0));
    chk("dc_valid", 64'(dc_req_valid), 64'(vh));
    pre = 0;
    for (int l = 0; l < W; l++) begin
      if (req[l]) begin
        chk("alloc_id", 64'(sb_alloc_id[l]), 64'((head_seq + cnt + pre) % D));
        pre++;
      end
    end
    @(posedge clk);
    if (ev && !fl) begin
      k = (int'(eid) - (head_seq % D) + D) % D;
      if (k < cnt && !ent[k].cmt) begin
        ent[k].dok = 1'b1; ent[k].addr = ea; ent[k].data = ed; ent[k].strb = es;
      end
    end
    c = $countones(cm);
    for (int j = 0; j < c; j++) begin
      ent[ncmt].cmt = 1'b1;
      exp_q.push_back('{addr: ent[ncmt].addr, data: ent[ncmt].data, strb: ent[ncmt].strb});
      ncmt++;
    end
    if (vh && rdy) begin
      void'(ent.pop_front());
      head_seq++;
      ncmt--;
    end
    if (fl) while (ent.size() > ncmt) void'(ent.pop_back());
    if (fire && mrdy && !fl) begin
      for (int j = 0; j < $countones(req); j++) ent.push_back('{default: 0});
    end
    #1;
  endtask

  // Longest run of retirable stores starting at the commit point.
  function automatic int avail_commits(input bit ev, input bit fl, input int kk);
    int a = 0;
    while (ncmt + a < ent.size() && a < W &&
           (ent[ncmt + a].dok || (ev && !fl && kk == ncmt + a))) a++;
    return a;
  endfunction

  initial begin
    logic [3:0]  req, eid, es, cm;
    logic [31:0] ea, ed;
    logic        fire, ev, rdy, fl;
    int          cnt, k, kk, c, placed, guard;

    rst_n = 1'b0;
    sb_alloc_req = '0; sb_alloc_fire = 1'b0; exe_valid = 1'b0; exe_sb_id = '0;
    exe_addr = '0; exe_data = '0; exe_strb = '0; commit_store = '0;
    dc_req_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(sb_alloc_ready), 64'(1));
    chk("rst_dc_valid", 64'(dc_req_valid), 64'(0));
    chk("rst_empty", 64'(sb_empty), 64'(1));
    chk("rst_addr", 64'(dc_req_addr), 64'(0));
    chk("rst_data", 64'(dc_req_data), 64'(0));
    chk("rst_strb", 64'(dc_req_strb), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: sparse group, then fill entry 0, commit, and hold off the D-cache.
    step(4'b1010, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 4'b0000, 1'b0, 1'b0);
    chk("empty_after_alloc", 64'(sb_empty), 64'(0));
    step(4'b0000, 1'b0, 1'b1, 4'd0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 4'b0001, 1'b0, 1'b0);
    repeat (3) step(4'b0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 4'b0000, 1'b1, 1'b0);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req  = 4'($urandom);
      fire = ($urandom % 10) < 7;
      fl   = ($urandom % 50) == 0;
      rdy  = ($urandom % 10) < 6;
      cnt  = ent.size();
      ev   = 1'b0;
      eid  = 4'($urandom);
      if ($urandom % 4 != 0) begin
        ev = 1'b1;
        if (cnt > ncmt && $urandom % 4 != 0) begin
          k   = ncmt + int'($urandom % 32'(cnt - ncmt));
          eid = 4'((head_seq + k) % D);
        end
      end
      ea = $urandom; ed = $urandom; es = 4'($urandom);
      kk = (int'(eid) - (head_seq % D) + D) % D;
      c  = ($urandom % 2 == 1) ? int'($urandom_range(0, 32'(avail_commits(ev, fl, kk)))) : 0;
      cm = '0;
      placed = 0;
      for (int l = 0; l < W; l++) begin
        if ((c - placed) == (W - l) || ((c - placed) > 0 && $urandom % 2 == 1)) begin
          cm[l] = 1'b1;
          placed++;
        end
      end
      step(req, fire, ev, eid, ea, ed, es, cm, rdy, fl);
    end

    // Wind down: fill, commit and drain everything left.
    guard = 0;
    while (ent.size() > 0 && guard < 400) begin
      ev = 1'b0;
      eid = '0;
      for (int j = ncmt; j < ent.size(); j++) begin
        if (!ent[j].dok && !ev) begin
          ev  = 1'b1;
          eid = 4'((head_seq + j) % D);
        end
      end
      kk = (int'(eid) - (head_seq % D) + D) % D;
      c  = avail_commits(ev, 1'b0, kk);
      cm = 4'((1 << c) - 1);
      step(4'b0000, 1'b0, ev, eid, $urandom, $urandom, 4'($urandom), cm, 1'b1, 1'b0);
      guard++;
    end
    if (guard >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 entries left", ent.size());
    end
    @(negedge clk);
    chk("final_empty", 64'(sb_empty), 64'(1));
    chk("final_dc_valid", 64'(dc_req_valid), 64'(0));
    chk("final_pending_drains", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
